// File: rtl/forward_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / forwarding controller.
// Holds the register-address width, the operand-mux select encoding and the
// packed shadow-stage records carried by the ID/EX, EX/MEM and MEM/WB copies.
package forward_ctrl_pkg;

  localparam int REG_AW = 5;

  // Operand-mux select encoding (matches the EX-stage 4-way operand muxes).
  localparam logic [1:0] FWD_RF   = 2'b00; // register-file data from ID/EX
  localparam logic [1:0] FWD_WB   = 2'b01; // MEM/WB write-back data
  localparam logic [1:0] FWD_MEM  = 2'b10; // EX/MEM ALU result
  localparam logic [1:0] FWD_RSVD = 2'b11; // reserved, never driven

  // Destination-side state common to every shadow stage.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } stage_t;

  // ID/EX additionally carries the source registers for the forward compare.
  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    stage_t            st;
  } idex_t;

endpackage

// File: rtl/forward_ctrl_stage_reg.sv
// hazard_stage_reg: one shadow pipeline stage.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low clear (all fields to zero)
//   en     - load enable; low freezes the stage
//   bubble - when loading, insert an all-zero bubble instead of d
//   d      - next-stage contents
//   q      - registered stage contents
module hazard_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= bubble ? '0 : d;
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// forward_ctrl: hazard and forwarding controller for the 5-stage pipeline.
// Tracks destination-register state in ID/EX, EX/MEM and MEM/WB shadows,
// produces the EX operand-mux selects and a one-cycle load-use stall.
// Ports:
//   clk_i, rst_i            - clock, async active-low reset
//   id_valid_i              - ID stage holds a real instruction
//   id_rs1_i/id_rs2_i/id_rd_i, id_regwrite_i, id_memread_i - ID instruction
//   flush_i                 - taken branch: ID instruction must not enter EX
//   hold_i                  - global freeze: no state changes
//   fwd_a_o/fwd_b_o         - EX operand A/B mux selects
//   stall_o                 - load-use stall (PC and IF/ID hold)
//   wb_rd_o/wb_we_o         - MEM/WB register-file write port controls
module forward_ctrl
  import forward_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic              wb_we_o
);

  idex_t  idex_d;
  idex_t  idex_q;
  stage_t exmem_q;
  stage_t memwb_q;
  logic   stall;
  logic   idex_bubble;

  // EX/MEM wins over MEM/WB; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input stage_t mem,
                                         input stage_t wb);
    if (mem.regwrite && (mem.rd != '0) && (mem.rd == rs)) return FWD_MEM;
    if (wb.regwrite && (wb.rd != '0) && (wb.rd == rs))    return FWD_WB;
    return FWD_RF;
  endfunction

  // Load in ID/EX whose result the ID instruction needs next cycle.
  // Hold suppresses it so a frozen pipeline never reports a stall.
  assign stall = id_valid_i && idex_q.st.memread && (idex_q.st.rd != '0) &&
                 ((idex_q.st.rd == id_rs1_i) || (idex_q.st.rd == id_rs2_i)) &&
                 !flush_i && !hold_i;

  assign idex_bubble = flush_i || stall || !id_valid_i;

  assign idex_d = '{rs1: id_rs1_i,
                    rs2: id_rs2_i,
                    st:  '{rd: id_rd_i, regwrite: id_regwrite_i, memread: id_memread_i}};

  // ---- ID -> ID/EX
  hazard_stage_reg #(.W($bits(idex_t))) u_idex (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .en     (!hold_i),
    .bubble (idex_bubble),
    .d      (idex_d),
    .q      (idex_q)
  );

  // ---- ID/EX -> EX/MEM (source fields dropped)
  hazard_stage_reg #(.W($bits(stage_t))) u_exmem (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .en     (!hold_i),
    .bubble (1'b0),
    .d      (idex_q.st),
    .q      (exmem_q)
  );

  // ---- EX/MEM -> MEM/WB
  hazard_stage_reg #(.W($bits(stage_t))) u_memwb (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .en     (!hold_i),
    .bubble (1'b0),
    .d      (exmem_q),
    .q      (memwb_q)
  );

  // The load flag has no consumer once the instruction reaches write-back.
  logic unused_memwb_memread;
  assign unused_memwb_memread = memwb_q.memread;

  assign fwd_a_o = fwd_sel(idex_q.rs1, exmem_q, memwb_q);
  assign fwd_b_o = fwd_sel(idex_q.rs2, exmem_q, memwb_q);
  assign stall_o = stall;
  assign wb_rd_o = memwb_q.rd;
  assign wb_we_o = memwb_q.regwrite;

endmodule

// File: tb/tb_forward_ctrl.sv
module tb_forward_ctrl;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } ins_t;

  typedef struct {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic [4:0] wrd;
    logic       wwe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       id_valid_i = 1'b0;
  logic [4:0] id_rs1_i = '0;
  logic [4:0] id_rs2_i = '0;
  logic [4:0] id_rd_i = '0;
  logic       id_regwrite_i = 1'b0;
  logic       id_memread_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       hold_i = 1'b0;
  logic [1:0] fwd_a_o;
  logic [1:0] fwd_b_o;
  logic       stall_o;
  logic [4:0] wb_rd_o;
  logic       wb_we_o;

  int checks = 0;
  int failures = 0;

  exp_t sb[$];
  // Instructions that entered EX, newest first: [0]=in EX, [1]=one ahead, [2]=two ahead.
  ins_t inflight[$];

  always #5 clk = ~clk;

  forward_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rd_i       (id_rd_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .flush_i       (flush_i),
    .hold_i        (hold_i),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o),
    .stall_o       (stall_o),
    .wb_rd_o       (wb_rd_o),
    .wb_we_o       (wb_we_o)
  );

  function automatic ins_t mk(input int rd, input int rs1, input int rs2,
                              input bit rw, input bit mr);
    ins_t i;
    i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.rw = rw; i.mr = mr;
    return i;
  endfunction

  function automatic ins_t bubble_ins();
    return mk(0, 0, 0, 1'b0, 1'b0);
  endfunction

  task automatic clear_model();
    inflight.delete();
    repeat (3) inflight.push_back(bubble_ins());
  endtask

  // Youngest older writer of rs wins: distance 1 -> EX/MEM, distance 2 -> MEM/WB.
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    for (int d = 1; d <= 2; d++)
      if (inflight[d].rw && inflight[d].rd == rs) return (d == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // One ID-stage cycle, entered at posedge+1. Optional hand-derived checks
  // (value >= 0) are applied to the DUT directly in addition to the scoreboard.
  task automatic step(input ins_t i, input bit v, input bit fl, input bit hd,
                      input int efa, input int efb, input int est, output bit st);
    exp_t e;
    id_valid_i = v; id_rs1_i = i.rs1; id_rs2_i = i.rs2; id_rd_i = i.rd;
    id_regwrite_i = i.rw; id_memread_i = i.mr; flush_i = fl; hold_i = hd;
    e.fa  = ref_fwd(inflight[0].rs1);
    e.fb  = ref_fwd(inflight[0].rs2);
    e.st  = v && !fl && !hd && inflight[0].mr && inflight[0].rd != 0 &&
            (inflight[0].rd == i.rs1 || inflight[0].rd == i.rs2);
    e.wrd = inflight[2].rd;
    e.wwe = inflight[2].rw;
    sb.push_back(e);
    st = e.st;
    #1;
    if (efa >= 0) chk("direct_fwd_a", 5'(fwd_a_o), 5'(efa));
    if (efb >= 0) chk("direct_fwd_b", 5'(fwd_b_o), 5'(efb));
    if (est >= 0) chk("direct_stall", 5'(stall_o), 5'(est));
    @(posedge clk);
    if (!hd) begin
      inflight.push_front((fl || e.st || !v) ? bubble_ins() : i);
      void'(inflight.pop_back());
    end
    #1;
  endtask

  task automatic nop(input int efa, input int efb, input int est);
    bit s;
    step(bubble_ins(), 1'b0, 1'b0, 1'b0, efa, efb, est, s);
  endtask

  task automatic ins(input ins_t i, input int efa, input int efb, input int est);
    bit s;
    step(i, 1'b1, 1'b0, 1'b0, efa, efb, est, s);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic do_reset();
    rst_i = 1'b0;
    #1;
    chk("rst_fwd_a", 5'(fwd_a_o), 5'd0);
    chk("rst_fwd_b", 5'(fwd_b_o), 5'd0);
    chk("rst_stall", 5'(stall_o), 5'd0);
    chk("rst_wb_rd", wb_rd_o, 5'd0);
    chk("rst_wb_we", 5'(wb_we_o), 5'd0);
    clear_model();
    @(posedge clk);
    #1;
    rst_i = 1'b1;
  endtask

  // Scoreboard monitor: compares each pending expectation mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("sb_fwd_a", 5'(fwd_a_o), 5'(e.fa));
      chk("sb_fwd_b", 5'(fwd_b_o), 5'(e.fb));
      chk("sb_stall", 5'(stall_o), 5'(e.st));
      chk("sb_wb_rd", wb_rd_o, e.wrd);
      chk("sb_wb_we", 5'(wb_we_o), 5'(e.wwe));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit   s;
    ins_t cur;
    bit   have;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;

    // Fill the pipeline with writers and a pending load, then reset.
    ins(mk(5, 1, 2, 1, 0), -1, -1, -1);
    ins(mk(8, 3, 4, 1, 1), -1, -1, -1);
    id_valid_i = 1'b1; id_rs1_i = 5'd8; id_rs2_i = 5'd0; id_memread_i = 1'b0;
    do_reset();
    ins(mk(6, 5, 2, 1, 0), -1, -1, -1);
    nop(0, 0, 0);

    // ALU chain, distance 1 then distance 2.
    repeat (3) nop(-1, -1, -1);
    ins(mk(5, 1, 2, 1, 0), -1, -1, 0);
    ins(mk(6, 5, 7, 1, 0), -1, -1, 0);
    nop(2, 0, 0);
    repeat (3) nop(-1, -1, -1);
    ins(mk(5, 1, 2, 1, 0), -1, -1, -1);
    ins(mk(10, 11, 12, 1, 0), -1, -1, -1);
    ins(mk(6, 5, 7, 1, 0), -1, -1, -1);
    nop(1, 0, 0);

    // Double match: EX/MEM priority on both operands.
    repeat (3) nop(-1, -1, -1);
    ins(mk(3, 1, 2, 1, 0), -1, -1, -1);
    ins(mk(3, 1, 2, 1, 0), -1, -1, -1);
    ins(mk(4, 3, 3, 1, 0), -1, -1, -1);
    nop(2, 2, 0);

    // Load-use: one stall cycle, then MEM/WB forward.
    repeat (3) nop(-1, -1, -1);
    ins(mk(8, 2, 0, 1, 1), -1, -1, 0);
    ins(mk(9, 8, 1, 1, 0), 0, 0, 1);
    ins(mk(9, 8, 1, 1, 0), 0, 0, 0);
    nop(1, 0, 0);

    // Load to x0 never stalls or forwards.
    repeat (3) nop(-1, -1, -1);
    ins(mk(0, 1, 2, 1, 1), -1, -1, -1);
    ins(mk(9, 0, 0, 1, 0), -1, -1, 0);
    nop(0, 0, 0);

    // Flush on the dependent op: no stall, bubble enters ID/EX.
    repeat (3) nop(-1, -1, -1);
    ins(mk(8, 2, 0, 1, 1), -1, -1, -1);
    step(mk(9, 8, 8, 1, 0), 1'b1, 1'b1, 1'b0, -1, -1, 0, s);
    nop(0, 0, 0);

    // Hold for 3 cycles during a forwarding pair, then resume.
    repeat (3) nop(-1, -1, -1);
    ins(mk(5, 1, 2, 1, 0), -1, -1, -1);
    ins(mk(6, 5, 7, 1, 0), -1, -1, -1);
    repeat (3) step(mk(7, 6, 6, 1, 0), 1'b1, 1'b0, 1'b1, 2, 0, 0, s);
    ins(mk(7, 6, 6, 1, 0), 2, 0, 0);
    nop(2, 2, 0);

    // Hold while a load-use hazard is visible: hold suppresses the stall.
    repeat (3) nop(-1, -1, -1);
    ins(mk(8, 2, 0, 1, 1), -1, -1, -1);
    step(mk(9, 8, 1, 1, 0), 1'b1, 1'b0, 1'b1, -1, -1, 0, s);
    ins(mk(9, 8, 1, 1, 0), -1, -1, 1);

    // Randomized traffic; upstream re-presents an instruction on stall or hold.
    have = 1'b0;
    cur = bubble_ins();
    for (int n = 0; n < 400; n++) begin
      bit v, fl, hd;
      if (n == 200) do_reset();
      if (!have) begin
        cur.rs1 = 5'($urandom_range(0, 7));
        cur.rs2 = 5'($urandom_range(0, 7));
        cur.rd  = 5'($urandom_range(0, 7));
        cur.rw  = ($urandom_range(0, 3) != 0);
        cur.mr  = cur.rw && ($urandom_range(0, 2) == 0);
      end
      v  = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 9) == 0);
      hd = ($urandom_range(0, 9) == 0);
      step(cur, v, fl, hd, -1, -1, -1, s);
      have = s || hd;
    end

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
